// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: generates the mic clock, samples the 1-bit stream and
// decimates it through a 3-stage CIC filter into a signed 8-bit audio sample.
module pdm_mic_frontend #(
  parameter int CLK_DIV    = 8,
  parameter int DECIM_LOG2 = 6
) (
  input  logic              wb_clk_i,
  input  logic              wb_reset_i,
  input  logic              enable,
  input  logic              pdm_data,
  output logic              pdm_clk,
  output logic signed [7:0] audio,
  output logic              sample_valid
);

  localparam int W     = 3 * DECIM_LOG2 + 2;
  localparam int SHIFT = 3 * DECIM_LOG2 - 7;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic signed [W-1:0] POS_LIM  = W'(127);
  localparam logic signed [W-1:0] NEG_LIM  = -(W'(128));

  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_next;
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic                  dec_last;
  logic                  bit_en;
  logic                  sync1;
  logic                  sync2;

  logic signed [W-1:0] pdm_step;
  logic signed [W-1:0] int1, int2, int3;
  logic signed [W-1:0] int1_next, int2_next, int3_next;

  logic                cap_pend;
  logic signed [W-1:0] cap;
  logic signed [W-1:0] cap_d, comb1_d, comb2_d;
  logic signed [W-1:0] comb1, comb2, comb3;
  logic signed [W-1:0] scaled;
  logic signed [7:0]   audio_sat;
  logic [1:0]          settle_cnt;

  always_comb begin
    div_next  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    bit_en    = enable && (div_cnt == DIV_LAST);
    dec_last  = &dec_cnt;
    pdm_step  = sync2 ? W'(1) : '1;
    int1_next = int1 + pdm_step;
    int2_next = int2 + int1_next;
    int3_next = int3 + int2_next;
  end

  // Comb stages run in the cycle after capture; only the final stage is scaled and clamped.
  always_comb begin
    comb1  = cap - cap_d;
    comb2  = comb1 - comb1_d;
    comb3  = comb2 - comb2_d;
    scaled = comb3 >>> SHIFT;
    if (scaled > POS_LIM) begin
      audio_sat = 8'sh7F;
    end else if (scaled < NEG_LIM) begin
      audio_sat = 8'sh80;
    end else begin
      audio_sat = scaled[7:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_data;
      sync2 <= sync1;
    end
  end

  // Disabling discards all filter history and any partially accumulated period,
  // but the last published sample stays visible on audio.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      div_cnt      <= '0;
      pdm_clk      <= 1'b0;
      dec_cnt      <= '0;
      int1         <= '0;
      int2         <= '0;
      int3         <= '0;
      cap          <= '0;
      cap_pend     <= 1'b0;
      cap_d        <= '0;
      comb1_d      <= '0;
      comb2_d      <= '0;
      settle_cnt   <= '0;
      audio        <= '0;
      sample_valid <= 1'b0;
    end else if (!enable) begin
      div_cnt      <= '0;
      pdm_clk      <= 1'b0;
      dec_cnt      <= '0;
      int1         <= '0;
      int2         <= '0;
      int3         <= '0;
      cap          <= '0;
      cap_pend     <= 1'b0;
      cap_d        <= '0;
      comb1_d      <= '0;
      comb2_d      <= '0;
      settle_cnt   <= '0;
      sample_valid <= 1'b0;
    end else begin
      div_cnt      <= div_next;
      pdm_clk      <= (div_next >= DIV_HALF);
      cap_pend     <= bit_en && dec_last;
      sample_valid <= 1'b0;
      if (bit_en) begin
        int1    <= int1_next;
        int2    <= int2_next;
        int3    <= int3_next;
        dec_cnt <= dec_cnt + 1'b1;
        if (dec_last) begin
          cap <= int3_next;
        end
      end
      if (cap_pend) begin
        cap_d   <= cap;
        comb1_d <= comb1;
        comb2_d <= comb2;
        if (settle_cnt == 2'd3) begin
          audio        <= audio_sat;
          sample_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Self-checking bench for pdm_mic_frontend: a density/timing model predicts pdm_clk,
// sample_valid and audio every cycle; literal pins anchor the model's values.
module tb_pdm_mic_frontend;

  localparam int CLK_DIV    = 8;
  localparam int DECIM_LOG2 = 6;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int PERIOD     = R * CLK_DIV;
  localparam int SHIFT      = 3 * DECIM_LOG2 - 7;

  logic              wb_clk_i;
  logic              wb_reset_i;
  logic              enable;
  logic              pdm_data;
  logic              pdm_clk;
  logic signed [7:0] audio;
  logic              sample_valid;

  pdm_mic_frontend #(.CLK_DIV(CLK_DIV), .DECIM_LOG2(DECIM_LOG2)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_reset_i  (wb_reset_i),
    .enable      (enable),
    .pdm_data    (pdm_data),
    .pdm_clk     (pdm_clk),
    .audio       (audio),
    .sample_valid(sample_valid)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int fails  = 0;
  int strobe_count = 0;

  logic [3:0] pat = 4'b0001;
  int         pat_len = 1;
  int         pat_idx = 0;
  int         exp_level = 0;
  logic       pdm_clk_last = 1'b0;

  int    pin_seq = 0;
  int    seen_seq = 0;
  string pin_name = "";
  int    pin_audio = 0;
  int    pin_valid = 0;
  int    pin_level = 0;
  int    pin_strobes = 0;

  int   run = 0;
  logic m_pdm = 1'b0;
  logic m_valid = 1'b0;
  int   m_audio = 0;

  // Output level of a CIC fed a periodic pattern: R^3 times the mean of the +/-1 bits.
  function automatic int level_of(input logic [3:0] p, input int len);
    int ones = 0;
    int val;
    for (int i = 0; i < len; i++) if (p[i]) ones++;
    val = (R * R * R * (2 * ones - len)) / len;
    val = val >>> SHIFT;
    if (val > 127) val = 127;
    if (val < -128) val = -128;
    return val;
  endfunction

  // Timing model: counts consecutive enabled cycles; a sample lands one cycle after
  // every period boundary, with the first three periods of each run suppressed.
  always @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      run = 0;
      m_pdm = 1'b0;
      m_valid = 1'b0;
      m_audio = 0;
    end else if (!enable) begin
      run = 0;
      m_pdm = 1'b0;
      m_valid = 1'b0;
    end else begin
      run++;
      m_pdm = (run % CLK_DIV) >= (CLK_DIV / 2);
      m_valid = ((run % PERIOD) == 1) && ((run / PERIOD) >= 4);
      if (m_valid) m_audio = exp_level;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (sample_valid === 1'b1) strobe_count++;
    checkOutput("pdm_clk", int'(pdm_clk), int'(m_pdm));
    checkOutput("sample_valid", int'(sample_valid), int'(m_valid));
    checkOutput("audio", int'(audio), m_audio);
    if (pin_seq != seen_seq) begin
      seen_seq = pin_seq;
      checkOutput({pin_name, ".audio"}, int'(audio), pin_audio);
      checkOutput({pin_name, ".valid"}, int'(sample_valid), pin_valid);
      checkOutput({pin_name, ".model_level"}, exp_level, pin_level);
      checkOutput({pin_name, ".strobes"}, strobe_count, pin_strobes);
    end
  end

  task automatic applyStimulus(input logic rst, input logic en);
    wb_reset_i = rst;
    enable = en;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (pdm_clk && !pdm_clk_last) begin
        pdm_data = pat[pat_idx % pat_len];
        pat_idx++;
      end
      pdm_clk_last = pdm_clk;
    end
  endtask

  task automatic setPattern(input logic [3:0] p, input int len);
    pat = p;
    pat_len = len;
    exp_level = level_of(p, len);
    pat_idx = 1;
    pdm_data = p[0];
    pdm_clk_last = 1'b0;
  endtask

  task automatic pin(input string name, input int a, input int v, input int lvl, input int s);
    pin_name = name;
    pin_audio = a;
    pin_valid = v;
    pin_level = lvl;
    pin_strobes = s;
    pin_seq++;
  endtask

  task automatic runPattern(input string name, input logic [3:0] p, input int len,
                            input int lvl, input int strobes);
    applyStimulus(1'b1, 1'b0);
    setPattern(p, len);
    tick(2);
    pin({name, "_reset"}, 0, 0, lvl, strobes - 1);
    applyStimulus(1'b0, 1'b1);
    tick(2300);
    pin(name, lvl, 0, lvl, strobes);
    tick(1);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0);
    setPattern(4'b0001, 1);
    tick(1);
    pin("reset_state", 0, 0, 127, 0);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    tick(3600);
    pin("full_pos", 127, 0, 127, 4);
    tick(1);

    runPattern("full_neg", 4'b0000, 1, -128, 5);
    runPattern("dens_1110", 4'b0111, 4, 64, 6);
    runPattern("dens_10", 4'b0001, 2, 0, 7);
    runPattern("dens_1000", 4'b0001, 4, -64, 8);

    applyStimulus(1'b1, 1'b0);
    setPattern(4'b0001, 1);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    tick(2300);
    applyStimulus(1'b0, 1'b0);
    tick(99);
    pin("gate_hold", 127, 0, 127, 9);
    applyStimulus(1'b0, 1'b1);
    tick(2100);
    pin("gate_resume", 127, 0, 127, 10);
    tick(1);

    applyStimulus(1'b1, 1'b1);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    tick(2047);
    applyStimulus(1'b0, 1'b0);
    tick(5);
    pin("drop_on_capture", 0, 0, 127, 10);
    applyStimulus(1'b0, 1'b1);
    tick(2049);
    pin("first_after_drop", 127, 1, 127, 11);
    tick(511);
    applyStimulus(1'b1, 1'b1);
    tick(1);
    pin("reset_on_output", 0, 0, 127, 11);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
